// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
//   state_e      : control FSM states (IDLE, RUN, HOLD)
//   booth_sel_e  : partial-product select decoded from a 3-bit Booth window
//   booth_decode : window -> select
//   w_of/nd_of/ncyc_of : operand width, digit count and RUN cycle count for a given XLEN/DIGITS
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  typedef enum logic [2:0] {ZERO, PA, P2A, M2A, MA} booth_sel_e;

  // Extended operand width: one extra bit carries signedness, one more keeps
  // the top Booth digit well-formed for unsigned operands.
  function automatic int w_of(input int xlen);
    return xlen + 2;
  endfunction

  function automatic int nd_of(input int xlen);
    return xlen / 2 + 1;
  endfunction

  function automatic int ncyc_of(input int xlen, input int digits);
    return (nd_of(xlen) + digits - 1) / digits;
  endfunction

  function automatic booth_sel_e booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return PA;
      3'b011:         return P2A;
      3'b100:         return M2A;
      3'b101, 3'b110: return MA;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mul_booth_pp.sv
// Combinational radix-4 Booth partial-product generator.
//   a_i   : W-bit two's complement multiplicand
//   win_i : Booth window {b[2i+1], b[2i], b[2i-1]}
//   pp_o  : W+1-bit signed partial product (0, +-A, +-2A)
module mul_booth_pp
  import mul_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [W-1:0] a_i,
  input  logic [2:0]   win_i,
  output logic [W:0]   pp_o
);

  booth_sel_e sel;
  logic [W:0] a_x;

  always_comb begin
    sel = booth_decode(win_i);
    a_x = {a_i[W-1], a_i};
    case (sel)
      PA:      pp_o = a_x;
      P2A:     pp_o = {a_i, 1'b0};
      M2A:     pp_o = -{a_i, 1'b0};
      MA:      pp_o = -a_x;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier, full 2*XLEN-bit product, per-operand
// signedness, DIGITS Booth digits retired per RUN cycle.
//   clock, reset (async, active high), flush (abort current op)
//   in_valid/in_ready/in_sign/in_a/in_b : request side
//   out_valid/out_ready/out_prod        : result side (held stable in HOLD)
// Optional: define MUL_EARLY_EXIT_EN to leave RUN as soon as the remaining
// multiplier bits are all equal (remaining digits would all be zero).
module mul_booth_iter
  import mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DIGITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [1:0]        in_sign,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2*XLEN-1:0] out_prod
);

  localparam int W  = w_of(XLEN);
  localparam int ND = nd_of(XLEN);
  localparam int PW = 2 * W;
  localparam int CW = $clog2(ND + DIGITS + 1);

  state_e          state_q;
  logic [W-1:0]    a_q;
  // Unretired multiplier bits with b[2k-1] at bit 0; refilled with the sign
  // bit so the window for digit k+j is always b_q[2j+2:2j].
  logic [W:0]      b_q;
  logic [PW-1:0]   p_q;
  logic [CW-1:0]   cnt_q;

  logic [DIGITS:0][PW-1:0]  p_chain;
  logic [DIGITS-1:0][W:0]   pp;

  logic [PW-1:0]   p_nxt;
  logic [W:0]      b_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            done;

  assign p_chain[0] = p_q;

  for (genvar j = 0; j < DIGITS; j++) begin : g_dig
    logic [PW-1:0] addend, sum;
    logic          act;

    mul_booth_pp #(.W(W)) u_pp (
      .a_i   (a_q),
      .win_i (b_q[2*j+2 -: 3]),
      .pp_o  (pp[j])
    );

    // Last cycle may retire fewer than DIGITS digits; idle stages pass through.
    assign act    = (int'(cnt_q) + j) < ND;
    assign addend = PW'({pp[j], {W{1'b0}}});
    assign sum    = p_chain[j] + addend;
    assign p_chain[j+1] = act ? PW'($signed(sum) >>> 2) : p_chain[j];
  end

  always_comb begin
    cnt_nxt = cnt_q + CW'(DIGITS);
    b_nxt   = (W+1)'($signed(b_q) >>> (2 * DIGITS));
    p_nxt   = p_chain[DIGITS];
    done    = cnt_nxt >= CW'(ND);
`ifdef MUL_EARLY_EXIT_EN
    // Remaining digits are all 000/111 -> pure shifts; apply them at once.
    if (!done && ((&b_nxt) || !(|b_nxt))) begin
      done  = 1'b1;
      p_nxt = PW'($signed(p_chain[DIGITS]) >>> (2 * (ND - int'(cnt_nxt))));
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && !flush) begin
          a_q     <= {{2{in_sign[1] & in_a[XLEN-1]}}, in_a};
          b_q     <= {{2{in_sign[0] & in_b[XLEN-1]}}, in_b, 1'b0};
          p_q     <= '0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: if (flush) begin
          state_q <= IDLE;
        end else begin
          p_q   <= p_nxt;
          b_q   <= b_nxt;
          cnt_q <= cnt_nxt;
          if (done) state_q <= HOLD;
        end
        HOLD: if (flush || out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == HOLD);
  assign out_prod  = p_q[2*XLEN-1:0];

endmodule

// File: tb/tb_mul_booth_iter.sv
module tb_mul_booth_iter;
  import mul_pkg::*;

  localparam int XLEN   = 32;
  localparam int DIGITS = 1;
  localparam int W      = XLEN + 2;
  localparam int ND     = XLEN / 2 + 1;
  localparam int NCYC   = (ND + DIGITS - 1) / DIGITS;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_ready;
  logic              in_valid = 1'b0;
  logic [1:0]        in_sign = 2'b00;
  logic [XLEN-1:0]   in_a = '0;
  logic [XLEN-1:0]   in_b = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [2*XLEN-1:0] out_prod;

  int checks = 0;
  int failures = 0;

  mul_booth_iter #(.XLEN(XLEN), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_ready(in_ready), .in_valid(in_valid), .in_sign(in_sign),
    .in_a(in_a), .in_b(in_b),
    .out_ready(out_ready), .out_valid(out_valid), .out_prod(out_prod)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the extended operands, low 2*XLEN bits.
  function automatic logic [63:0] ref_prod(input logic [1:0] sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [W-1:0]   ea, eb;
    logic signed [2*W-1:0] pr;
    ea = sg[1] ? {{2{a[31]}}, a} : {2'b00, a};
    eb = sg[0] ? {{2{b[31]}}, b} : {2'b00, b};
    pr = ea * eb;
    return pr[63:0];
  endfunction

`ifdef MUL_EARLY_EXIT_EN
  // Cycles from acceptance to first out_valid: stop after the first RUN cycle
  // whose unretired multiplier bits are all equal.
  function automatic int exp_lat(input logic [1:0] sg, input logic [31:0] b);
    logic signed [W-1:0] eb, rest;
    int k;
    eb = sg[0] ? {{2{b[31]}}, b} : {2'b00, b};
    for (int c = 1; c <= NCYC; c++) begin
      k = c * DIGITS;
      if (k >= ND) return c + 1;
      rest = eb >>> (2 * k - 1);
      if (rest == '0 || rest == '1) return c + 1;
    end
    return NCYC + 1;
  endfunction
`else
  function automatic int exp_lat(input logic [1:0] sg, input logic [31:0] b);
    return (sg[0] | b[0]) ? NCYC + 1 : NCYC + 1;
  endfunction
`endif

  // Present a request; returns in cycle t0+1 (just after the accept edge).
  task automatic issue(input logic [1:0] sg, input logic [31:0] a, input logic [31:0] b);
    chk("idle_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_sign = sg; in_a = a; in_b = b;
    @(posedge clock); #1;
    in_valid = 1'b0; in_sign = 2'($urandom); in_a = $urandom; in_b = $urandom;
    chk("busy_ready", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!out_valid && c < 100) begin
      @(posedge clock); #1;
      c++;
    end
  endtask

  task automatic run_op(input logic [1:0] sg, input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [63:0] expd;
    int c;
    expd = ref_prod(sg, a, b);
    issue(sg, a, b);
    wait_valid(c);
    chk("latency", 64'(c + 1), 64'(exp_lat(sg, b)));
    chk("prod", out_prod, expd);
    for (int i = 0; i < bp; i++) begin
      @(posedge clock); #1;
      in_a = $urandom; in_b = $urandom;
    end
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_prod", out_prod, expd);
    chk("hold_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("post_ready", {63'd0, in_ready}, 64'd1);
    chk("post_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int c, nv;
    logic [31:0] ra, rb;
    logic [1:0]  rs;

    #1;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_prod", out_prod, 64'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Directed cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'd5, 32'd3, 0);
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b11, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(2'b01, 32'h1234_5678, 32'h0000_0000, 0);
    run_op(2'b00, 32'd0, 32'h9ABC_DEF0, 2);
    // Backpressure: 5 cycles with out_ready low
    run_op(2'b00, 32'h0001_0001, 32'hDEAD_BEEF, 5);

    // Flush in IDLE blocks acceptance
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd3; in_b = 32'd3; #1;
    chk("flush_idle_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_idle_noacc", {63'd0, in_ready}, 64'd1);

    // Flush mid-RUN at t0+6
    issue(2'b00, 32'h1234_5678, 32'h9234_5679);
    repeat (5) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; #1;
    chk("flush_run_idle", {63'd0, in_ready}, 64'd1);
    nv = 0;
    repeat (25) begin @(posedge clock); #1; if (out_valid) nv++; end
    chk("flush_run_novalid", 64'(nv), 64'd0);
    run_op(2'b00, 32'd7, 32'd9, 0);

    // Flush in HOLD drops the result
    issue(2'b11, 32'hFFFF_FFF9, 32'd11);
    wait_valid(c);
    chk("hold_prod_pre", out_prod, ref_prod(2'b11, 32'hFFFF_FFF9, 32'd11));
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; #1;
    chk("flush_hold_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_hold_ready", {63'd0, in_ready}, 64'd1);

    // Reset mid-RUN
    issue(2'b00, 32'hCAFE_F00D, 32'h8765_4321);
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1; #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_prod", out_prod, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Random operations
    for (int i = 0; i < 30; i++) begin
      rs = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = rb & 32'h0000_00FF;
        1: ra = 32'hFFFF_FFFF;
        2: rb = 32'hFFFF_FFF0 | rb[3:0];
        default: ;
      endcase
      run_op(rs, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_booth_iter.md
# mul_booth_iter

Parametrised iterative radix-4 Booth multiplier producing the full 2·XLEN-bit product of two XLEN-bit operands, with per-operand signedness. It retires DIGITS Booth digits per cycle and optionally exits early once the remaining multiplier digits are all zero. It sits in the execute stage behind the M-extension issue logic, using a ready/valid handshake on both sides and a pipeline-flush input.

## Interface
- XLEN, 32: operand width; must be even and ≥ 8.
- DIGITS, 1: radix-4 digits retired per RUN cycle; allowed values 1, 2, 4.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  abort the current operation and discard any result.
- in_ready  out  1  the block can accept an operation.
- in_valid  in  1  operation request.
- in_sign  in  2  bit 1 marks in_a as signed; bit 0 marks in_b as signed.
- in_a  in  XLEN  multiplicand.
- in_b  in  XLEN  multiplier.
- out_ready  in  1  the consumer accepts the result.
- out_valid  out  1  out_prod is valid.
- out_prod  out  2·XLEN  product.

## Operation
- **Operand extension.** Both operands are extended to W = XLEN+2 bits. An operand is sign-extended if its in_sign bit is set, and zero-extended otherwise.
- **Digit count.** ND = XLEN/2+1 digits. Digit i is decoded from multiplier bits {b[2i+1], b[2i], b[2i−1]}, with b[−1] = 0.
- **Booth encoding.**
  - 001 and 010 select +A.
  - 011 selects +2A.
  - 100 selects −2A.
  - 101 and 110 select −A.
  - 000 and 111 select 0.
- **Accumulator.** The accumulator P is 2W bits wide.
  - Each digit performs P ← (P + (pp << W)) >>> 2, an arithmetic shift on the 2W-bit sum.
  - All arithmetic is two's complement modulo 2^(2W).
  - out_prod = P[2·XLEN−1:0].
- **States.**
  - IDLE:
    - in_ready = ~flush.
    - On in_valid & in_ready: latch A and B, clear P, clear the digit counter, go to RUN.
  - RUN:
    - Each cycle retires min(DIGITS, remaining) digits, applied sequentially inside the cycle, and advances the counter.
    - Go to HOLD after the cycle that retires digit ND−1.
  - HOLD:
    - out_valid = 1 and P is frozen.
    - Go to IDLE when out_ready is high.
- **Flush.**
  - In RUN or HOLD, flush forces the next state to IDLE. No result is ever presented for the aborted operation.
  - In IDLE, flush blocks acceptance.
  - flush has priority over out_ready.
- **Stability.** While out_valid = 1, out_prod is stable.
- **Unused bits.** in_a and in_b are ignored outside an accepting cycle.
- **Reset.**
  - Asynchronous reset puts the block in IDLE with P = 0 and the counter at 0.
  - Outputs under reset: in_ready = 1 (if flush is low), out_valid = 0, out_prod = 0.
  - Reset asserted mid-RUN or mid-HOLD drops the operation.

## Timing
- **Acceptance cycle.** Call the accepting cycle t0. RUN occupies t0+1 … t0+N, with N = ceil(ND/DIGITS).
- **Result cycle.** out_valid is first high at t0+N+1.
  - XLEN=32, DIGITS=1: N=17, out_valid at t0+18.
  - XLEN=32, DIGITS=2: N=9, out_valid at t0+10.
- **Back-to-back issue.** The earliest next acceptance is the cycle after the HOLD handshake, because in_ready depends only on the IDLE state. There is no combinational path from in_valid to in_ready.
- **Backpressure.** If out_ready is low, HOLD persists indefinitely with out_prod unchanged.

## Configuration
- **MUL_EARLY_EXIT_EN defined.**
  - At the end of every RUN cycle, if the unretired multiplier bits b[W−1 : 2k−1] are all equal, the block goes directly to HOLD. Here k is the number of digits retired so far.
  - In that same cycle P is additionally shifted by >>> 2·(ND−k).
  - The minimum latency is therefore data-dependent, and the result is bit-identical to the full run.
- **MUL_EARLY_EXIT_EN undefined.**
  - Latency is fixed at N+1 cycles.
  - No detector or variable shifter is synthesised.

## Structure
- **Package mul_pkg.**
  - State enum: IDLE, RUN, HOLD.
  - Booth select typedef: ZERO, PA, P2A, M2A, MA.
  - Function booth_decode(3-bit) returning the select.
  - Width helper constants.
- **Sub-module mul_booth_pp.**
  - Combinational; takes A (W bits) and a 3-bit digit window, returns the W+1-bit signed partial product.
  - Instantiated DIGITS times.

## Test plan
- **Unsigned max × max.** in_sign=00, a=b=0xFFFFFFFF → out_prod 0xFFFFFFFE00000001 at t0+18 (DIGITS=1, early exit off).
- **Signed −1 × −1.** in_sign=11, a=b=0xFFFFFFFF → 0x0000000000000001.
- **Mixed signedness.** in_sign=10, a=0xFFFFFFFE (−2), b=0xFFFFFFFF unsigned → 0xFFFFFFFE00000002.
- **Backpressure.** Hold out_ready low for 5 cycles after out_valid rises → out_valid and out_prod are stable, in_ready=0. Then raise out_ready → in_ready=1 on the next cycle.
- **Flush mid-RUN.** Assert flush at t0+6 → out_valid never rises and the block is in IDLE at t0+7. The following operation 7×9 returns 63.
- **Early exit.** With MUL_EARLY_EXIT_EN, a=5, b=3, in_sign=00 → 15 with out_valid at t0+3. Without the macro, the same stimulus gives out_valid at t0+18.
